mc_control_fsm: RTL and testbench

//  Multi-cycle control unit for the RV32I-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/mc_control_fsm.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for an RV32I-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// registers decoded datapath selects, and adds bus timeout, illegal-opcode trap and retire count.
module mc_control_fsm #(
    parameter int unsigned MEM_WAIT_EN  = 1,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned ILLEGAL_TRAP = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic [3:0]       alu_sel,
    output logic [3:0]       jump_ctrl,
    output logic [1:0]       rs1_mux_sel,
    output logic [1:0]       rs2_mux_sel,
    output logic             imm_mux_sel,
    output logic [1:0]       rf_mux_sel,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);
    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] AluSub = 4'd0, AluAdd = 4'd1, AluAnd = 4'd2, AluOr  = 4'd3;
    localparam logic [3:0] AluXor = 4'd4, AluSrl = 4'd5, AluSll = 4'd6, AluSra = 4'd7;
    localparam logic [3:0] JmpNpc = 4'd0, JmpOffpc = 4'd1, JmpNeq = 4'd2, JmpEq = 4'd3;
    localparam logic [3:0] JmpSlt = 4'd4, JmpUlt = 4'd5, JmpJalr = 4'd6;

    localparam logic [6:0] OpR     = 7'b0110011, OpImm   = 7'b0010011, OpLoad = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011, OpLui   = 7'b0110111, OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111, OpJalr  = 7'b1100111, OpBranch = 7'b1100011;
    localparam logic [6:0] OpNop   = 7'b0000000;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        ClsNop, ClsR, ClsImm, ClsLoad, ClsStore, ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, dec_cls;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [3:0]       alu_q, alu_d, dec_alu;
    logic [3:0]       jmp_q, jmp_d, dec_jmp;
    logic [1:0]       rs1_q, rs1_d, dec_rs1;
    logic [1:0]       rs2_q, rs2_d, dec_rs2;
    logic             imm_q, imm_d, dec_imm;
    logic [1:0]       rf_q, rf_d, dec_rf;
    logic             illegal_q, illegal_d, dec_illegal;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ready, timeout;

    // Shared ALU function decode; only R-type may select SUB via funct7.
    function automatic logic [3:0] alu_func(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic is_r);
        logic [3:0] f;
        f = AluAdd;
        case (f3)
            3'b000:  if (is_r && f7 == 7'b0100000) f = AluSub;
            3'b001:  f = AluSll;
            3'b100:  f = AluXor;
            3'b101:  f = f7[5] ? AluSra : AluSrl;
            3'b110:  f = AluOr;
            3'b111:  f = AluAnd;
            default: f = AluAdd;
        endcase
        return f;
    endfunction

    always_comb begin
        dec_cls     = ClsNop;
        dec_alu     = AluAdd;
        dec_jmp     = JmpNpc;
        dec_rs1     = 2'b00;
        dec_rs2     = 2'b00;
        dec_imm     = 1'b0;
        dec_rf      = 2'b00;
        dec_illegal = 1'b0;
        case (ir[6:0])
            OpR: begin
                dec_cls = ClsR;
                dec_rs1 = 2'b11;
                dec_alu = alu_func(ir[14:12], ir[31:25], 1'b1);
            end
            OpImm: begin
                dec_cls = ClsImm;
                dec_rs1 = 2'b11;
                dec_rs2 = 2'b01;
                dec_alu = alu_func(ir[14:12], ir[31:25], 1'b0);
            end
            OpLoad: begin
                dec_cls = ClsLoad;
                dec_rs1 = 2'b11;
                dec_rs2 = 2'b01;
                dec_rf  = 2'b01;
            end
            OpStore: begin
                dec_cls = ClsStore;
                dec_rs1 = 2'b11;
                dec_rs2 = 2'b01;
            end
            OpLui: begin
                dec_cls = ClsLui;
                dec_rs1 = 2'b01;
                dec_rs2 = 2'b10;
            end
            OpAuipc: begin
                dec_cls = ClsAuipc;
                dec_rs2 = 2'b10;
            end
            OpJal: begin
                dec_cls = ClsJal;
                dec_rs2 = 2'b01;
                dec_imm = 1'b1;
                dec_rf  = 2'b10;
                dec_jmp = JmpOffpc;
            end
            OpJalr: begin
                dec_cls = ClsJalr;
                dec_rs1 = 2'b11;
                dec_rs2 = 2'b01;
                dec_rf  = 2'b10;
                dec_jmp = JmpJalr;
            end
            OpBranch: begin
                dec_cls = ClsBranch;
                dec_rs1 = 2'b11;
                dec_alu = AluSub;
                case (ir[14:12])
                    3'b001:  dec_jmp = JmpNeq;
                    3'b100:  dec_jmp = JmpSlt;
                    3'b110:  dec_jmp = JmpUlt;
                    default: dec_jmp = JmpEq;
                endcase
            end
            OpNop:   dec_cls = ClsNop;
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        wait_d     = wait_q;
        alu_d      = alu_q;
        jmp_d      = jmp_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        rf_d       = rf_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        retired_d  = retired_q;
        ir_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        instr_done = 1'b0;
        ready      = (MEM_WAIT_EN == 0) || mem_ready;
        // Completion has priority over the limit, so ready on the final wait cycle still succeeds.
        timeout    = (MEM_WAIT_EN != 0) && (wait_q == WaitW'(MEM_TIMEOUT - 1));

        case (state_q)
            StFetch: begin
                mem_re = 1'b1;
                if (ready) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                cls_d = dec_cls;
                alu_d = dec_alu;
                jmp_d = dec_jmp;
                rs1_d = dec_rs1;
                rs2_d = dec_rs2;
                imm_d = dec_imm;
                rf_d  = dec_rf;
                if (dec_illegal && ILLEGAL_TRAP != 0) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsBranch, ClsNop: begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end
                    ClsJal, ClsJalr: begin
                        pc_we   = 1'b1;
                        state_d = StWb;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                mem_re = (cls_q == ClsLoad);
                mem_we = (cls_q == ClsStore);
                if (ready) begin
                    if (cls_q == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end
                end else if (timeout) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWb: begin
                rf_we      = 1'b1;
                pc_we      = !(cls_q == ClsJal || cls_q == ClsJalr);
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StHalt;
        endcase

        if (state_d != state_q) wait_d = '0;
        if (instr_done) retired_d = retired_q + CNT_W'(1);

        // Strobes are suppressed while reset is held so an aborted access emits nothing.
        if (rst) begin
            ir_we      = 1'b0;
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            pc_we      = 1'b0;
            rf_we      = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            cls_q     <= ClsNop;
            wait_q    <= '0;
            alu_q     <= AluAdd;
            jmp_q     <= JmpNpc;
            rs1_q     <= 2'b00;
            rs2_q     <= 2'b00;
            imm_q     <= 1'b0;
            rf_q      <= 2'b00;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            alu_q     <= alu_d;
            jmp_q     <= jmp_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            rf_q      <= rf_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    assign state       = state_q;
    assign alu_sel     = alu_q;
    assign jump_ctrl   = jmp_q;
    assign rs1_mux_sel = rs1_q;
    assign rs2_mux_sel = rs2_q;
    assign imm_mux_sel = imm_q;
    assign rf_mux_sel  = rf_q;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: table of instructions with expected selects, strobe
// counts and latency, scoreboarded per instruction, plus hand-written trap/timeout/reset cases.
module tb_mc_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_ready;
    logic [31:0] ir;
    logic        ir_we, mem_re, mem_we, pc_we, rf_we, imm_mux_sel, instr_done, illegal, bus_err;
    logic [3:0]  alu_sel, jump_ctrl;
    logic [1:0]  rs1_mux_sel, rs2_mux_sel, rf_mux_sel;
    logic [2:0]  state;
    logic [31:0] retired;

    mc_control_fsm u_dut (
        .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready),
        .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we), .pc_we(pc_we), .rf_we(rf_we),
        .alu_sel(alu_sel), .jump_ctrl(jump_ctrl), .rs1_mux_sel(rs1_mux_sel),
        .rs2_mux_sel(rs2_mux_sel), .imm_mux_sel(imm_mux_sel), .rf_mux_sel(rf_mux_sel),
        .state(state), .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err),
        .retired(retired)
    );

    // Second instance: no wait states, unknown opcodes run as NOP, 4-bit retire counter.
    logic        rst2, mem_ready2;
    logic [31:0] ir2;
    logic        ir_we2, mem_re2, mem_we2, pc_we2, rf_we2, imm2, done2, illegal2, bus_err2;
    logic [3:0]  alu2, jmp2;
    logic [1:0]  rs1_2, rs2_2, rf2;
    logic [2:0]  state2;
    logic [3:0]  retired2;

    mc_control_fsm #(
        .MEM_WAIT_EN(0), .MEM_TIMEOUT(16), .ILLEGAL_TRAP(0), .CNT_W(4)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .ir(ir2), .mem_ready(mem_ready2),
        .ir_we(ir_we2), .mem_re(mem_re2), .mem_we(mem_we2), .pc_we(pc_we2), .rf_we(rf_we2),
        .alu_sel(alu2), .jump_ctrl(jmp2), .rs1_mux_sel(rs1_2), .rs2_mux_sel(rs2_2),
        .imm_mux_sel(imm2), .rf_mux_sel(rf2), .state(state2), .instr_done(done2),
        .illegal(illegal2), .bus_err(bus_err2), .retired(retired2)
    );

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          fwait, mwait, cycles;
        logic [3:0]  alu, jmp;
        logic [1:0]  rs1, rs2;
        logic        imm;
        logic [1:0]  rf;
        int          n_rf_we, n_pc_we, n_mem_re, n_mem_we;
    } vec_t;

    typedef struct {
        logic        done;
        int          cycles;
        logic [3:0]  alu, jmp;
        logic [1:0]  rs1, rs2;
        logic        imm;
        logic [1:0]  rf;
        int          n_rf_we, n_pc_we, n_mem_re, n_mem_we;
    } obs_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_retired;
    vec_t vecs[22];
    vec_t sb_q[$];

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] instr, input int fw,
                                input int mw, input int cyc, input logic [3:0] alu,
                                input logic [3:0] jmp, input logic [1:0] rs1,
                                input logic [1:0] rs2, input logic imm, input logic [1:0] rf,
                                input int nrf, input int npc, input int nre, input int nwe);
        vec_t v;
        v.name = name; v.ir = instr; v.fwait = fw; v.mwait = mw; v.cycles = cyc;
        v.alu = alu; v.jmp = jmp; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.rf = rf;
        v.n_rf_we = nrf; v.n_pc_we = npc; v.n_mem_re = nre; v.n_mem_we = nwe;
        return v;
    endfunction

    // Memory model answers after fwait/mwait low cycles in FETCH/MEM; starts and ends at a negedge.
    task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait,
                             output obs_t o);
        int         st_cnt;
        logic [2:0] prev;
        o.done = 1'b0; o.cycles = 0; o.alu = '0; o.jmp = '0; o.rs1 = '0; o.rs2 = '0;
        o.imm = 1'b0; o.rf = '0; o.n_rf_we = 0; o.n_pc_we = 0; o.n_mem_re = 0; o.n_mem_we = 0;
        ir     = instr;
        st_cnt = 0;
        prev   = 3'd5;
        for (int c = 0; c < 200 && !o.done; c++) begin
            if (state != prev) st_cnt = 0;
            prev      = state;
            mem_ready = (state == 3'd0) ? (st_cnt >= fwait) :
                        (state == 3'd3) ? (st_cnt >= mwait) : 1'b0;
            #1;
            o.cycles++;
            o.n_rf_we  += int'(rf_we);
            o.n_pc_we  += int'(pc_we);
            o.n_mem_re += int'(mem_re);
            o.n_mem_we += int'(mem_we);
            if (instr_done) begin
                o.done = 1'b1;
                o.alu = alu_sel; o.jmp = jump_ctrl; o.rs1 = rs1_mux_sel;
                o.rs2 = rs2_mux_sel; o.imm = imm_mux_sel; o.rf = rf_mux_sel;
            end
            st_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_retired = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        vec_t e;
        logic found;

        //        name        ir            fw  mw cyc alu   jmp   rs1    rs2    imm   rf     rf pc re we
        vecs[0]  = mk("add",   32'h002081B3, 0,  0, 4, 4'd1, 4'd0, 2'b11, 2'b00, 1'b0, 2'b00, 1, 1, 1, 0);
        vecs[1]  = mk("sub",   32'h402081B3, 0,  0, 4, 4'd0, 4'd0, 2'b11, 2'b00, 1'b0, 2'b00, 1, 1, 1, 0);
        vecs[2]  = mk("xor",   32'h0020C1B3, 0,  0, 4, 4'd4, 4'd0, 2'b11, 2'b00, 1'b0, 2'b00, 1, 1, 1, 0);
        vecs[3]  = mk("sra",   32'h4020D1B3, 0,  0, 4, 4'd7, 4'd0, 2'b11, 2'b00, 1'b0, 2'b00, 1, 1, 1, 0);
        vecs[4]  = mk("andi",  32'h0050F193, 0,  0, 4, 4'd2, 4'd0, 2'b11, 2'b01, 1'b0, 2'b00, 1, 1, 1, 0);
        vecs[5]  = mk("srai",  32'h4010D193, 0,  0, 4, 4'd7, 4'd0, 2'b11, 2'b01, 1'b0, 2'b00, 1, 1, 1, 0);
        vecs[6]  = mk("lui",   32'h123451B7, 0,  0, 4, 4'd1, 4'd0, 2'b01, 2'b10, 1'b0, 2'b00, 1, 1, 1, 0);
        vecs[7]  = mk("auipc", 32'h12345197, 0,  0, 4, 4'd1, 4'd0, 2'b00, 2'b10, 1'b0, 2'b00, 1, 1, 1, 0);
        vecs[8]  = mk("jal",   32'h008000EF, 0,  0, 4, 4'd1, 4'd1, 2'b00, 2'b01, 1'b1, 2'b10, 1, 1, 1, 0);
        vecs[9]  = mk("jalr",  32'h000100E7, 0,  0, 4, 4'd1, 4'd6, 2'b11, 2'b01, 1'b0, 2'b10, 1, 1, 1, 0);
        vecs[10] = mk("beq",   32'h00208463, 0,  0, 3, 4'd0, 4'd3, 2'b11, 2'b00, 1'b0, 2'b00, 0, 1, 1, 0);
        vecs[11] = mk("bne",   32'h00209463, 0,  0, 3, 4'd0, 4'd2, 2'b11, 2'b00, 1'b0, 2'b00, 0, 1, 1, 0);
        vecs[12] = mk("blt",   32'h0020C463, 0,  0, 3, 4'd0, 4'd4, 2'b11, 2'b00, 1'b0, 2'b00, 0, 1, 1, 0);
        vecs[13] = mk("bltu",  32'h0020E463, 0,  0, 3, 4'd0, 4'd5, 2'b11, 2'b00, 1'b0, 2'b00, 0, 1, 1, 0);
        vecs[14] = mk("bge",   32'h0020D463, 0,  0, 3, 4'd0, 4'd3, 2'b11, 2'b00, 1'b0, 2'b00, 0, 1, 1, 0);
        vecs[15] = mk("lw",    32'h0000A183, 0,  0, 5, 4'd1, 4'd0, 2'b11, 2'b01, 1'b0, 2'b01, 1, 1, 2, 0);
        vecs[16] = mk("lw_w3", 32'h0000A183, 0,  3, 8, 4'd1, 4'd0, 2'b11, 2'b01, 1'b0, 2'b01, 1, 1, 5, 0);
        vecs[17] = mk("sw",    32'h0020A023, 0,  0, 4, 4'd1, 4'd0, 2'b11, 2'b01, 1'b0, 2'b00, 0, 1, 1, 1);
        vecs[18] = mk("sw_w2", 32'h0020A023, 0,  2, 6, 4'd1, 4'd0, 2'b11, 2'b01, 1'b0, 2'b00, 0, 1, 1, 3);
        vecs[19] = mk("nop",   32'h00000000, 0,  0, 3, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0, 2'b00, 0, 1, 1, 0);
        vecs[20] = mk("f15",   32'h002081B3, 15, 0, 19, 4'd1, 4'd0, 2'b11, 2'b00, 1'b0, 2'b00, 1, 1, 16, 0);
        vecs[21] = mk("lw_fm", 32'h0000A183, 2,  3, 10, 4'd1, 4'd0, 2'b11, 2'b01, 1'b0, 2'b01, 1, 1, 7, 0);

        rst = 1'b1; mem_ready = 1'b0; ir = '0;
        rst2 = 1'b1; mem_ready2 = 1'b0; ir2 = 32'hFFFFFFFF;
        exp_retired = 0;
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset strobes", 32'({ir_we, mem_re, mem_we, pc_we, rf_we, instr_done}), 32'd0);
        chk("reset alu_sel", 32'(alu_sel), 32'd1);
        chk("reset selects", 32'({jump_ctrl, rs1_mux_sel, rs2_mux_sel, imm_mux_sel, rf_mux_sel}),
            32'd0);
        chk("reset flags", 32'({illegal, bus_err}), 32'd0);
        chk("reset retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            sb_q.push_back(vecs[i]);
            run_instr(vecs[i].ir, vecs[i].fwait, vecs[i].mwait, o);
            e = sb_q.pop_front();
            chk({e.name, " done"}, 32'(o.done), 32'd1);
            chk({e.name, " cycles"}, o.cycles, e.cycles);
            chk({e.name, " alu_sel"}, 32'(o.alu), 32'(e.alu));
            chk({e.name, " jump_ctrl"}, 32'(o.jmp), 32'(e.jmp));
            chk({e.name, " rs1_mux_sel"}, 32'(o.rs1), 32'(e.rs1));
            chk({e.name, " rs2_mux_sel"}, 32'(o.rs2), 32'(e.rs2));
            chk({e.name, " imm_mux_sel"}, 32'(o.imm), 32'(e.imm));
            chk({e.name, " rf_mux_sel"}, 32'(o.rf), 32'(e.rf));
            chk({e.name, " rf_we count"}, o.n_rf_we, e.n_rf_we);
            chk({e.name, " pc_we count"}, o.n_pc_we, e.n_pc_we);
            chk({e.name, " mem_re count"}, o.n_mem_re, e.n_mem_re);
            chk({e.name, " mem_we count"}, o.n_mem_we, e.n_mem_we);
            exp_retired++;
            chk({e.name, " retired"}, retired, exp_retired);
        end

        // Illegal opcode traps to HALT and stays there with no strobes.
        ir = 32'hFFFFFFFF;
        mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k >= 2) begin
                chk("illegal state", 32'(state), 32'd7);
                chk("illegal strobes", 32'({ir_we, mem_re, mem_we, pc_we, rf_we, instr_done}),
                    32'd0);
                chk("illegal flags", 32'({illegal, bus_err}), 32'b10);
            end
            @(negedge clk);
        end
        chk("illegal retired", retired, exp_retired);

        // FETCH stuck waiting: 16 wait cycles then HALT with bus_err.
        do_reset();
        #1;
        chk("sticky cleared", 32'({illegal, bus_err}), 32'd0);
        @(negedge clk);
        do_reset();
        ir = 32'h002081B3;
        mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (k == 15) begin
                chk("timeout last wait state", 32'(state), 32'd0);
                chk("timeout last wait bus_err", 32'(bus_err), 32'd0);
            end
            if (k == 16 || k == 19) begin
                chk("timeout halt state", 32'(state), 32'd7);
                chk("timeout bus_err", 32'({illegal, bus_err}), 32'b01);
                chk("timeout mem_re", 32'(mem_re), 32'd0);
            end
            @(negedge clk);
        end

        // Reset mid-MEM of a store aborts it asynchronously.
        do_reset();
        run_instr(32'h002081B3, 0, 0, o);
        chk("pre-abort retired", retired, 32'd1);
        ir = 32'h0020A023;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            mem_ready = (state == 3'd0);
            #1;
            if (state == 3'd3) found = 1'b1;
            else @(negedge clk);
        end
        chk("sw reached MEM", 32'(found), 32'd1);
        chk("sw mem_we in MEM", 32'(mem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort mem_we", 32'(mem_we), 32'd0);
        chk("abort state", 32'(state), 32'd0);
        chk("abort retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // No-wait, no-trap instance: illegal opcodes retire as 3-cycle NOPs; counter wraps at 16.
        @(negedge clk);
        rst2 = 1'b0;
        for (int k = 0; k < 51; k++) begin
            #1;
            chk($sformatf("dut2 state k=%0d", k), 32'(state2), 32'(k % 3));
            chk($sformatf("dut2 retired k=%0d", k), 32'(retired2), 32'((k / 3) % 16));
            chk($sformatf("dut2 pc_we k=%0d", k), 32'(pc_we2), 32'(k % 3 == 2));
            @(negedge clk);
        end
        chk("dut2 illegal", 32'({illegal2, bus_err2}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
